// File: rtl/keyload_pkg.sv
// Shared constants, FSM state type and the CRC-8 step function for the key loader.
package keyload_pkg;

  localparam int unsigned KEY_W = 64;
  localparam int unsigned OP_W  = 32;
  localparam int unsigned CRC_W = 8;
  localparam int unsigned CNT_W = $clog2(KEY_W);

  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT_KEY = 2'd1,
    ST_SHIFT_CRC = 2'd2,
    ST_CHECK     = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] add1;
    logic [OP_W-1:0] add2;
  } op_pair_t;

  // One serial CRC-8 update, init 0, no final XOR.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                 input logic data_bit);
    logic fb;
    fb = crc[CRC_W-1] ^ data_bit;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_W'(0));
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator; clear wins over enable.
module crc8_serial
  import keyload_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             data_bit,
  output logic [CRC_W-1:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc8_step(crc, data_bit);
    end
  end

endmodule

// File: rtl/keyinput_loader_xor64.sv
// Serial key loader with CRC-8 check, committing a verified key to the locked
// adder and gating the operand register on key validity.
module keyinput_loader_xor64
  import keyload_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             key_sen,
  input  logic             key_sdi,
  input  logic             op_valid_i,
  input  logic [OP_W-1:0]  add1_i,
  input  logic [OP_W-1:0]  add2_i,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_valid,
  output logic             key_error,
  output logic             busy,
  output logic [OP_W-1:0]  add1_o,
  output logic [OP_W-1:0]  add2_o,
  output logic             op_valid_o,
  output logic             op_reject
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [KEY_W-1:0]   keyinput_d;
  logic [CRC_W-1:0]   crc_rx_q, crc_rx_d;
  logic [CRC_W-1:0]   crc_calc;
  logic               key_valid_d, key_error_d;
  logic               crc_clear_c, crc_en_c;
  op_pair_t           op_in;

  assign op_in = '{add1: add1_i, add2: add2_i};

  crc8_serial u_crc (
    .clk      (clk),
    .rst      (rst),
    .clear    (crc_clear_c),
    .enable   (crc_en_c),
    .data_bit (key_sdi),
    .crc      (crc_calc)
  );

  // Next-state and load datapath; load_start restarts from any state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    crc_rx_d    = crc_rx_q;
    keyinput_d  = keyinput;
    key_valid_d = key_valid;
    key_error_d = key_error;
    crc_clear_c = 1'b0;
    crc_en_c    = 1'b0;

    if (load_start) begin
      state_d     = ST_SHIFT_KEY;
      cnt_d       = '0;
      shadow_d    = '0;
      crc_rx_d    = '0;
      keyinput_d  = '0;
      key_valid_d = 1'b0;
      key_error_d = 1'b0;
      crc_clear_c = 1'b1;
    end else begin
      case (state_q)
        ST_SHIFT_KEY: begin
          if (key_sen) begin
            shadow_d[cnt_q] = key_sdi;
            crc_en_c        = 1'b1;
            cnt_d           = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_W'(KEY_W - 1)) begin
              state_d = ST_SHIFT_CRC;
            end
          end
        end
        ST_SHIFT_CRC: begin
          if (key_sen) begin
            crc_rx_d = {crc_rx_q[CRC_W-2:0], key_sdi};
            if (cnt_q == CNT_W'(CRC_W - 1)) begin
              state_d = ST_CHECK;
              cnt_d   = '0;
            end else begin
              cnt_d = CNT_W'(cnt_q + 1'b1);
            end
          end
        end
        ST_CHECK: begin
          if (crc_rx_q == crc_calc) begin
            keyinput_d  = shadow_q;
            key_valid_d = 1'b1;
          end else begin
            key_error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      crc_rx_q  <= '0;
      keyinput  <= '0;
      key_valid <= 1'b0;
      key_error <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      crc_rx_q  <= crc_rx_d;
      keyinput  <= keyinput_d;
      key_valid <= key_valid_d;
      key_error <= key_error_d;
      busy      <= (state_d != ST_IDLE);
    end
  end

  // Operand stage sees the pre-edge key_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      add1_o     <= '0;
      add2_o     <= '0;
      op_valid_o <= 1'b0;
      op_reject  <= 1'b0;
    end else begin
      op_valid_o <= op_valid_i && key_valid;
      op_reject  <= op_valid_i && !key_valid;
      if (op_valid_i && key_valid) begin
        add1_o <= op_in.add1;
        add2_o <= op_in.add2;
      end
    end
  end

endmodule

// File: doc/keyinput_loader_xor64.md
Name: keyinput_loader_xor64

Overview:
- Upstream stage for the XOR-locked 32-bit error-tolerant adder netlists.
- Loads the 64-bit unlock key over a serial interface and checks it with CRC-8.
- Commits the key to the locked adder's keyinput bus.
- Registers operands and forwards them only while a verified key is committed, so the locked core never computes with a partial or corrupt key.

Parameters:
- KEY_W, 64, key width (equals locked-core keyinput width).
- OP_W, 32, operand width.
- CRC_POLY, 8'h07, CRC-8 polynomial; init 8'h00, no final XOR.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  pulse; begins a key load.
- key_sen  in  1  serial bit strobe; one bit accepted per cycle where high.
- key_sdi  in  1  serial data bit.
- op_valid_i  in  1  operand pair valid.
- add1_i  in  OP_W  operand A.
- add2_i  in  OP_W  operand B.
- keyinput  out  KEY_W  committed key to the locked adder.
- key_valid  out  1  committed key passed CRC.
- key_error  out  1  last load failed CRC; sticky until next load_start or rst.
- busy  out  1  load in progress (SHIFT_KEY, SHIFT_CRC or CHECK).
- add1_o  out  OP_W  registered operand A.
- add2_o  out  OP_W  registered operand B.
- op_valid_o  out  1  registered operands valid.
- op_reject  out  1  one-cycle pulse; operand dropped because key_valid=0.

Behaviour:
- Reset (sync, rst=1 at clock edge):
  - All outputs and state go to 0: keyinput=0, key_valid=0, key_error=0, busy=0, add1_o=add2_o=0, op_valid_o=0, op_reject=0.
  - FSM goes to IDLE; shadow key, CRC and counter are cleared.
  - Reset mid-load abandons the load with no commit.
- FSM states: IDLE, SHIFT_KEY, SHIFT_CRC, CHECK.
  - IDLE: load_start=1 -> SHIFT_KEY. Clear counter, shadow, crc_calc and crc_rx. Clear key_error. Set key_valid=0 and keyinput=0 in the same edge.
  - SHIFT_KEY:
    - Each cycle with key_sen=1: shadow[cnt] <= key_sdi (key bit 0 first).
    - Same cycle, crc_calc updates: fb = crc_calc[7]^key_sdi; crc_calc <= {crc_calc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
    - cnt increments; after the 64th accepted bit -> SHIFT_CRC with cnt=0.
    - key_sen=0 cycles stall; no timeout.
  - SHIFT_CRC: 8 accepted bits shift into crc_rx MSB-first. After the 8th -> CHECK.
  - CHECK (exactly one cycle):
    - If crc_rx == crc_calc: keyinput <= shadow, key_valid <= 1.
    - Else: keyinput stays 0, key_error <= 1.
    - Then -> IDLE.
- load_start while busy restarts the load from SHIFT_KEY and discards partial data. load_start has priority over key_sen in the same cycle, and that cycle's key bit is not consumed.
- busy=1 in SHIFT_KEY, SHIFT_CRC and CHECK. key_valid/key_error update on the edge leaving CHECK. Load latency is 72 accepted bits + 1 cycle.
- keyinput only changes on reset, load_start, or a CHECK pass; it is stable otherwise.
- Operand stage, one-cycle latency, registered outputs:
  - op_valid_i=1 and key_valid=1: add1_o/add2_o capture the inputs, op_valid_o=1 next cycle.
  - op_valid_i=1 and key_valid=0: op_reject=1 next cycle, op_valid_o=0, add*_o hold.
  - op_valid_i=0: op_valid_o=0, op_reject=0, add*_o hold.
  - Operands arriving in the cycle where load_start clears key_valid see the pre-edge key_valid=1 and are forwarded. The following cycle rejects.
- No backpressure; the locked core is combinational and always ready.

Decomposition:
- Package keyload_pkg holds:
  - FSM state enum (2-bit).
  - KEY_W, OP_W, CRC_W=8, CRC_POLY constants.
  - A function crc8_step(crc, bit) shared with the bench model.
- One sub-module, crc8_serial:
  - Inputs: clear, enable, bit.
  - Output: 8-bit crc.
  - Instantiated once for the key path.
- FSM, counter and operand register live in the top.

Test Plan:
- Reset, then op_valid_i=1, add1_i=32'h0000_0005, add2_i=32'h0000_0003 -> op_reject pulses 1 cycle later; op_valid_o=0; keyinput=0.
- load_start, 64 zero key bits, CRC bits 8'h00 with key_sen=1 continuously -> busy high 73 cycles; then key_valid=1, keyinput=64'h0, key_error=0.
- Nonzero key 64'hA5A5_5A5A_0F0F_F0F0 with CRC from crc8_step model -> key_valid=1, keyinput equals key. Then op 32'hFFFF_FFFF + 32'h1 -> add1_o/add2_o match, op_valid_o=1 after 1 cycle.
- Same key with CRC LSB flipped -> key_error=1, key_valid=0, keyinput=0. Next operand rejected.
- key_sen toggled 1/0 every cycle during load -> same result as the contiguous load; busy high 145 cycles.
- load_start mid-key (after 30 bits), then a full valid load -> only the second key committed. rst asserted at bit 40 of a load -> all outputs 0 next cycle, FSM IDLE.
